// File: rtl/mc_cu.sv
// Multi-cycle CPU control unit. Walks each instruction through IF/ID/EXE/MEM/WB,
// waits on the memory handshake, flags illegal opcodes and memory timeouts, counts retirements.
module mc_cu #(
  parameter int HAS_GT       = 1,
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             iord,
  output logic             wmem,
  output logic             wir,
  output logic             wpc,
  output logic             wreg,
  output logic             regrt,
  output logic             m2reg,
  output logic             shift,
  output logic             aluimm,
  output logic             sext,
  output logic             jal,
  output logic             selpc,
  output logic             bsel4,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam int WAIT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [2:0]        state_r, state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
  logic [CNT_W-1:0]  retired_r;
  logic              illegal_r, timeout_r;
  logic              retire_s, set_illegal_s, set_timeout_s;

  logic r_alu_s, i_alu_s, is_lw_s, is_sw_s, is_beq_s, is_bne_s;
  logic is_j_s, is_jal_s, is_jr_s, legal_s;
  logic [3:0] ex_aluc_s;
  logic ex_shift_s, ex_imm_s, ex_sext_s;

  logic mem_req_s, iord_s, wmem_s, wir_s, wpc_s, wreg_s;
  logic regrt_s, m2reg_s, shift_s, aluimm_s, sext_s, jal_s, selpc_s, bsel4_s;
  logic [3:0] aluc_s;
  logic [1:0] pcsource_s;

  // Instruction decode: class of the current IR plus its EXE-stage ALU controls.
  always_comb begin
    r_alu_s    = 1'b0;
    i_alu_s    = 1'b0;
    is_lw_s    = 1'b0;
    is_sw_s    = 1'b0;
    is_beq_s   = 1'b0;
    is_bne_s   = 1'b0;
    is_j_s     = 1'b0;
    is_jal_s   = 1'b0;
    is_jr_s    = 1'b0;
    ex_aluc_s  = 4'b0000;
    ex_shift_s = 1'b0;
    ex_imm_s   = 1'b0;
    ex_sext_s  = 1'b0;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: begin r_alu_s = 1'b1; ex_aluc_s = 4'b0000; end
          6'b100010: begin r_alu_s = 1'b1; ex_aluc_s = 4'b0100; end
          6'b100100: begin r_alu_s = 1'b1; ex_aluc_s = 4'b0001; end
          6'b100101: begin r_alu_s = 1'b1; ex_aluc_s = 4'b0101; end
          6'b100110: begin r_alu_s = 1'b1; ex_aluc_s = 4'b0010; end
          6'b000000: begin r_alu_s = 1'b1; ex_aluc_s = 4'b0011; ex_shift_s = 1'b1; end
          6'b000010: begin r_alu_s = 1'b1; ex_aluc_s = 4'b0111; ex_shift_s = 1'b1; end
          6'b000011: begin r_alu_s = 1'b1; ex_aluc_s = 4'b1111; ex_shift_s = 1'b1; end
          6'b001000: begin is_jr_s = 1'b1; end
          6'b100111: begin
            if (HAS_GT != 0) begin
              r_alu_s   = 1'b1;
              ex_aluc_s = 4'b1011;
            end else begin
              r_alu_s   = 1'b0;
            end
          end
          default: begin r_alu_s = 1'b0; end
        endcase
      end
      6'b001000: begin i_alu_s = 1'b1; ex_imm_s = 1'b1; ex_sext_s = 1'b1; ex_aluc_s = 4'b0000; end
      6'b001100: begin i_alu_s = 1'b1; ex_imm_s = 1'b1; ex_aluc_s = 4'b0001; end
      6'b001101: begin i_alu_s = 1'b1; ex_imm_s = 1'b1; ex_aluc_s = 4'b0101; end
      6'b001110: begin i_alu_s = 1'b1; ex_imm_s = 1'b1; ex_aluc_s = 4'b0010; end
      6'b001111: begin i_alu_s = 1'b1; ex_imm_s = 1'b1; ex_aluc_s = 4'b0110; end
      6'b100011: begin is_lw_s = 1'b1; ex_imm_s = 1'b1; ex_sext_s = 1'b1; end
      6'b101011: begin is_sw_s = 1'b1; ex_imm_s = 1'b1; ex_sext_s = 1'b1; end
      6'b000100: begin is_beq_s = 1'b1; ex_sext_s = 1'b1; ex_aluc_s = 4'b0100; end
      6'b000101: begin is_bne_s = 1'b1; ex_sext_s = 1'b1; ex_aluc_s = 4'b0100; end
      6'b000010: begin is_j_s = 1'b1; end
      6'b000011: begin is_jal_s = 1'b1; end
      default:   begin r_alu_s = 1'b0; end
    endcase
    legal_s = r_alu_s | i_alu_s | is_lw_s | is_sw_s | is_beq_s | is_bne_s |
              is_j_s | is_jal_s | is_jr_s;
  end

  // Per-state strobes, next state, retire and wait-counter update.
  always_comb begin
    state_nxt_s   = state_r;
    retire_s      = 1'b0;
    set_illegal_s = 1'b0;
    set_timeout_s = 1'b0;
    wait_nxt_s    = {WAIT_W{1'b0}};
    mem_req_s     = 1'b0;
    iord_s        = 1'b0;
    wmem_s        = 1'b0;
    wir_s         = 1'b0;
    wpc_s         = 1'b0;
    wreg_s        = 1'b0;
    regrt_s       = 1'b0;
    m2reg_s       = 1'b0;
    shift_s       = 1'b0;
    aluimm_s      = 1'b0;
    sext_s        = 1'b0;
    jal_s         = 1'b0;
    selpc_s       = 1'b0;
    bsel4_s       = 1'b0;
    aluc_s        = 4'b0000;
    pcsource_s    = 2'b00;
    case (state_r)
      S_IF: begin
        mem_req_s = 1'b1;
        selpc_s   = 1'b1;
        bsel4_s   = 1'b1;
        if (mem_ready) begin
          wir_s       = 1'b1;
          wpc_s       = 1'b1;
          state_nxt_s = S_ID;
        end else begin
          state_nxt_s = S_IF;
        end
      end
      S_ID: begin
        if (is_j_s || is_jal_s) begin
          wpc_s       = 1'b1;
          pcsource_s  = 2'b11;
          wreg_s      = is_jal_s;
          jal_s       = is_jal_s;
          retire_s    = 1'b1;
          state_nxt_s = S_IF;
        end else if (is_jr_s) begin
          wpc_s       = 1'b1;
          pcsource_s  = 2'b10;
          retire_s    = 1'b1;
          state_nxt_s = S_IF;
        end else if (legal_s) begin
          state_nxt_s = S_EXE;
        end else begin
          set_illegal_s = 1'b1;
          state_nxt_s   = S_HALT;
        end
      end
      S_EXE: begin
        aluc_s   = ex_aluc_s;
        shift_s  = ex_shift_s;
        aluimm_s = ex_imm_s;
        sext_s   = ex_sext_s;
        if (is_beq_s || is_bne_s) begin
          wpc_s       = is_beq_s ? z : ~z;
          pcsource_s  = 2'b01;
          retire_s    = 1'b1;
          state_nxt_s = S_IF;
        end else if (is_lw_s || is_sw_s) begin
          state_nxt_s = S_MEM;
        end else begin
          state_nxt_s = S_WB;
        end
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        aluimm_s  = 1'b1;
        sext_s    = 1'b1;
        wmem_s    = is_sw_s;
        if (mem_ready) begin
          retire_s    = is_sw_s;
          state_nxt_s = is_sw_s ? S_IF : S_WB;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        wreg_s      = 1'b1;
        m2reg_s     = is_lw_s;
        regrt_s     = i_alu_s | is_lw_s;
        retire_s    = 1'b1;
        state_nxt_s = S_IF;
      end
      S_HALT: begin
        state_nxt_s = S_HALT;
      end
      default: begin
        state_nxt_s = S_HALT;
      end
    endcase
    // An answered request clears the counter, so a same-cycle mem_ready beats the timeout.
    if (mem_req_s && !mem_ready) begin
      wait_nxt_s = wait_cnt_r + WAIT_ONE;
      if ((WAIT_TIMEOUT != 0) && (wait_cnt_r == WAIT_LAST)) begin
        set_timeout_s = 1'b1;
        state_nxt_s   = S_HALT;
      end else begin
        set_timeout_s = 1'b0;
      end
    end else begin
      wait_nxt_s = {WAIT_W{1'b0}};
    end
  end

  // State, wait counter, sticky error flags and retirement counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IF;
      wait_cnt_r <= {WAIT_W{1'b0}};
      retired_r  <= {CNT_W{1'b0}};
      illegal_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      illegal_r  <= illegal_r | set_illegal_s;
      timeout_r  <= timeout_r | set_timeout_s;
      if (retire_s) begin
        retired_r <= retired_r + CNT_ONE;
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign state    = state_r;
  assign mem_req  = mem_req_s & ~reset;
  assign wmem     = wmem_s & ~reset;
  assign wir      = wir_s & ~reset;
  assign wpc      = wpc_s & ~reset;
  assign wreg     = wreg_s & ~reset;
  assign iord     = iord_s;
  assign regrt    = regrt_s;
  assign m2reg    = m2reg_s;
  assign shift    = shift_s;
  assign aluimm   = aluimm_s;
  assign sext     = sext_s;
  assign jal      = jal_s;
  assign selpc    = selpc_s;
  assign bsel4    = bsel4_s;
  assign aluc     = aluc_s;
  assign pcsource = pcsource_s;
  assign illegal  = illegal_r;
  assign timeout  = timeout_r;
  assign retired  = retired_r;

endmodule

// File: doc/mc_cu.md
# mc_cu

Multi-cycle CPU control unit: the sequential successor to the single-cycle decoder. It steps each instruction through fetch, decode, execute, memory and writeback states, and waits on a variable-latency memory handshake. It also detects illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register and the shared single-memory datapath of the multi-cycle CPU.

## Interface
- `HAS_GT`, default 1: 1 decodes R-type func 100111 (gt); 0 treats it as illegal.
- `WAIT_TIMEOUT`, default 255: number of consecutive unanswered memory-wait cycles that forces HALT; 0 disables the timeout.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clock  in  1`: the only clock; every register updates on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `op, func  in  6 each`: fields from the datapath IR; stable from ID onward.
- `z  in  1`: ALU zero flag.
- `mem_ready  in  1`: memory completes the current request this cycle.
- `state  out  3`: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
- `mem_req, iord, wmem, wir, wpc, wreg  out  1 each`: memory request, address = ALU result, memory write, IR load, PC load, register write.
- `regrt, m2reg, shift, aluimm, sext, jal  out  1 each`: datapath selects, with the same meanings as in the single-cycle CPU.
- `selpc  out  1`: ALU A = PC.
- `bsel4  out  1`: ALU B = constant 4.
- `aluc  out  4`: ALU operation.
- `pcsource  out  2`: 00 = ALU result, 01 = branch target, 10 = rs, 11 = jump target.
- `illegal, timeout  out  1 each`: sticky error flags.
- `retired  out  CNT_W`: count of retired instructions.

## Operation
- Decoded instructions: add, sub, and, or, xor, sll, srl, sra, jr, gt (if `HAS_GT`), addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. All use standard MIPS encodings.
- aluc values:
  - add, addi, lw, sw, PC+4: 0000
  - and, andi: 0001
  - xor, xori: 0010
  - sll: 0011
  - sub, beq, bne: 0100
  - or, ori: 0101
  - lui: 0110
  - srl: 0111
  - gt: 1011
  - sra: 1111
- Each output is a combinational function of state, op, func, z and mem_ready. Any strobe not listed for a state is 0.
- **IF:** mem_req=1, iord=0, selpc=1, bsel4=1, aluc=0000.
  - Stay in IF while mem_ready=0.
  - On mem_ready=1: wir=1, wpc=1, pcsource=00, go to ID.
- **ID:**
  - No legal decode: set illegal, go to HALT.
  - j: wpc=1, pcsource=11, retire, go to IF.
  - jal: additionally wreg=1, jal=1.
  - jr: wpc=1, pcsource=10, retire, go to IF.
  - Anything else: go to EXE.
- **EXE:** aluc, shift, aluimm and sext are driven per instruction.
  - beq: wpc=z. bne: wpc=~z. Both use pcsource=01, retire and go to IF.
  - lw, sw: go to MEM.
  - All others: go to WB.
- **MEM:** mem_req=1, iord=1, aluc=0000, aluimm=1, sext=1; wmem=1 for sw.
  - Stay in MEM while mem_ready=0.
  - On mem_ready=1: sw retires and goes to IF; lw goes to WB.
- **WB:** wreg=1, m2reg=lw. regrt=1 for addi, andi, ori, xori, lw and lui. Retire, go to IF.
- **HALT:** every strobe is 0. Only reset leaves HALT.
- **Wait counter:** increments on each cycle with mem_req=1 and mem_ready=0, and clears otherwise. When it reaches `WAIT_TIMEOUT` (if nonzero), set timeout and go to HALT on the next edge.
- **Retire:** retired increments by 1 on the edge that completes an instruction and wraps modulo 2^CNT_W.

## Timing
- **Reset** (active on the edge):
  - state=IF, retired=0, illegal=0, timeout=0, wait counter=0.
  - While reset is high, mem_req, wmem, wir, wpc and wreg are forced to 0.
  - Reset asserted mid-instruction abandons that instruction with no strobes issued.
- **Latency with mem_ready held at 1:**
  - j, jal, jr: 2 cycles
  - beq, bne: 3 cycles
  - R-type, immediate ALU ops, sw: 4 cycles
  - lw: 5 cycles
  - Each cycle mem_ready is low in IF or MEM adds 1 cycle.
- **Memory handshake:** mem_req stays high until mem_ready. wmem is held for the whole MEM stay, and the write takes effect on the mem_ready cycle.
- **Simultaneous events:**
  - mem_ready=1 on the same cycle the wait counter would hit the limit: the access wins and no timeout is raised.
  - illegal and timeout can never be set in the same cycle.

## Test plan
- **add then lw**, mem_ready=1, reset released at cycle 0:
  - state sequence 0,1,2,4,0,1,2,3,4,0.
  - wreg is high only in the two WB cycles; retired=2.
- **beq**, z=1 vs z=0: wpc=1 with pcsource=01 in EXE in one case and wpc=0 in the other. Both take 3 cycles and both add 1 to retired.
- **jal:** in ID, wreg=1, jal=1, wpc=1, pcsource=11; next state=IF.
- **sw with mem_ready low for 3 cycles in MEM:**
  - wmem and mem_req high for 4 cycles, then state=IF.
  - With `WAIT_TIMEOUT`=2, timeout=1 and state=5 instead.
- **Illegal and disabled gt:** op=111111, or gt with `HAS_GT`=0, gives illegal=1 and state=5. Strobes stay 0 until reset.
- **Wrap and mid-operation reset:**
  - `CNT_W`=2: 5 j instructions give retired=1.
  - Reset asserted in MEM gives state=0 and all strobes 0 on the next cycle.
